// File: rtl/stream_packet_arbiter.sv
// Weighted round-robin, packet-locking arbiter for a shared N-to-1 stream mux.
// One requester is granted at a time. The grant is held until that requester's
// last beat transfers, so packets never interleave. A port may send up to its
// weight in packets back-to-back before the grant rotates.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid       per-port request (stream valid)
//   req_last        per-port last flag of the current head beat
//   weight          per-port packets-per-turn, WEIGHT_WIDTH bits each (0 means 1)
//   beat_accept     a beat from the granted port transferred this cycle
//   grant_valid     a grant is held
//   grant_id        index of the granted port
//   grant_onehot    one-hot of grant_id, zero when no grant is held
//   credits_left    packets remaining in this turn, including the current one
//   protocol_error  sticky: beat_accept seen while no grant was held
module stream_packet_arbiter #(
   parameter int unsigned PORTS        = 2,
   parameter int unsigned ID_WIDTH     = $clog2(PORTS),
   parameter int unsigned WEIGHT_WIDTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [PORTS-1:0]                req_valid,
   input  logic [PORTS-1:0]                req_last,
   input  logic [PORTS*WEIGHT_WIDTH-1:0]   weight,
   input  logic                            beat_accept,
   output logic                            grant_valid,
   output logic [ID_WIDTH-1:0]             grant_id,
   output logic [PORTS-1:0]                grant_onehot,
   output logic [WEIGHT_WIDTH-1:0]         credits_left,
   output logic                            protocol_error
);

   localparam int unsigned SW = ID_WIDTH + 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                   state_q, state_d;
   logic [ID_WIDTH-1:0]      ptr_q, ptr_d;
   logic [ID_WIDTH-1:0]      id_q, id_d;
   logic [WEIGHT_WIDTH-1:0]  cred_q, cred_d;
   logic                     gv_q, gv_d;
   logic [PORTS-1:0]         onehot_q, onehot_d;
   logic                     err_q, err_d;

   logic [WEIGHT_WIDTH-1:0]  weight_arr [PORTS];
   logic [WEIGHT_WIDTH-1:0]  win_weight;
   logic [ID_WIDTH-1:0]      win;
   logic [ID_WIDTH-1:0]      cand;
   logic [SW-1:0]            sum;
   logic                     found;
   logic                     pkt_end;

   // Unpack the flat weight bus into per-port entries.
   always_comb begin
      for (int i = 0; i < int'(PORTS); i++) begin
         weight_arr[i] = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
   end

   // Round-robin search: scan ascending from the pointer with wrap, first hit wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      cand  = '0;
      for (int unsigned off = 0; off < PORTS; off++) begin
         sum = SW'(ptr_q) + SW'(off);
         if (sum >= SW'(PORTS)) begin
            sum = sum - SW'(PORTS);
         end
         cand = sum[ID_WIDTH-1:0];
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign win_weight = weight_arr[win];
   assign pkt_end    = beat_accept && req_last[id_q];

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      cred_d   = cred_q;
      err_d    = err_q;
      gv_d     = 1'b0;
      onehot_d = '0;

      case (state_q)
         IDLE: begin
            if (beat_accept) begin
               err_d = 1'b1;
            end
            if (found) begin
               state_d = LOCKED;
               id_d    = win;
               cred_d  = (win_weight == '0) ? WEIGHT_WIDTH'(1) : win_weight;
            end
         end
         LOCKED: begin
            if (pkt_end) begin
               // Continue the turn without a bubble only if the port has more to send.
               if (cred_q > WEIGHT_WIDTH'(1) && req_valid[id_q]) begin
                  cred_d = cred_q - WEIGHT_WIDTH'(1);
               end else begin
                  state_d = IDLE;
                  cred_d  = '0;
                  ptr_d   = (id_q == ID_WIDTH'(PORTS - 1)) ? '0 : id_q + ID_WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      gv_d = (state_d == LOCKED);
      if (gv_d) begin
         onehot_d = PORTS'(1) << id_d;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         cred_q   <= '0;
         gv_q     <= 1'b0;
         onehot_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         cred_q   <= cred_d;
         gv_q     <= gv_d;
         onehot_q <= onehot_d;
         err_q    <= err_d;
      end
   end

   assign grant_valid    = gv_q;
   assign grant_id       = id_q;
   assign grant_onehot   = onehot_q;
   assign credits_left   = cred_q;
   assign protocol_error = err_q;

endmodule

// File: doc/stream_packet_arbiter.md
Name: stream_packet_arbiter

Overview:
- Weighted round-robin, packet-locking arbiter that generates the select for a shared N-to-1 stream datapath (merge mux plus its id/last sidebands).
- Grants one requester at a time and holds the grant until that requester's last beat transfers, so packets never interleave.
- Each port may send up to its configured number of packets back-to-back before the grant rotates.
- Sits beside the merge mux: the mux steers by grant_id and reports beat transfers back via beat_accept.

Parameters:
- PORTS, 2, number of requesters (≥2).
- ID_WIDTH, $clog2(PORTS), width of grant_id.
- WEIGHT_WIDTH, 4, width of each per-port packet-credit weight.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  PORTS  per-port request (input stream valid).
- req_last  input  PORTS  per-port last flag of the current head beat.
- weight  input  PORTS*WEIGHT_WIDTH  packets per turn for port i, bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; value 0 is treated as 1; sampled only at grant time.
- beat_accept  input  1  a beat from the granted port transferred this cycle (valid&&ready at the mux output).
- grant_valid  output  1  a grant is held.
- grant_id  output  ID_WIDTH  index of the granted port.
- grant_onehot  output  PORTS  one-hot of grant_id, all zero when grant_valid=0.
- credits_left  output  WEIGHT_WIDTH  packets remaining in the current turn, including the current one.
- protocol_error  output  1  sticky flag: beat_accept received while grant_valid=0.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - grant_valid=0, grant_id=0, grant_onehot=0, credits_left=0, protocol_error=0.
  - Round-robin pointer=0, state=IDLE.
  - Reset mid-packet discards the lock with no completion.
- All outputs are registered; there is no combinational path from any input to any output.
- IDLE state:
  - Search req_valid starting at the pointer, ascending with wrap; the first set bit wins.
  - On a hit, at the next edge: grant_valid=1, grant_id=winner, credits_left=max(weight[winner],1), state=LOCKED.
  - With no request, remain in IDLE.
  - Latency from a req_valid rise to grant_valid is 1 cycle.
- LOCKED state:
  - The grant is held regardless of req_valid; the granted port may drop valid mid-packet and the lock persists.
  - beat_accept with req_last[grant_id]=0: no state change.
  - beat_accept with req_last[grant_id]=1 (packet end):
    - If credits_left>1 and req_valid[grant_id]=1 in the same cycle: credits_left-1, stay LOCKED on the same port with no bubble.
    - Otherwise: pointer=(grant_id+1) mod PORTS, grant_valid=0, credits_left=0, state=IDLE.
  - The IDLE bubble costs 1 cycle; re-arbitration occurs in the following cycle.
  - Other ports' requests are ignored while LOCKED.
- beat_accept while IDLE: ignored for state; protocol_error set to 1 and held until reset.
- Pointer wrap: after port PORTS-1 the pointer returns to 0.
- A single-beat packet (last=1 on the first beat) is a complete packet and consumes one credit.
- Fairness: every continuously requesting port is granted within (PORTS-1) turns of other ports.

Test Plan:
- Reset, then req_valid=2'b11, weights 1/1, each port sends 4-beat packets (last on beat 3), beat_accept every cycle -> grants alternate 0,1,0,1; grant_id never changes mid-packet; 1 idle cycle between packets.
- PORTS=4, weight[2]=3, others 1; all ports request, 1-beat packets -> grant order 0,1,2,2,2,3,0; credits_left on port 2 reads 3,2,1.
- Port 0 granted, deasserts req_valid for 5 cycles mid-packet while port 1 requests -> grant_id stays 0 and grant_valid stays 1 until port 0's last beat transfers, then port 1 is granted.
- weight[1]=0, port 1 requests continuously -> treated as 1: exactly one packet per turn, credits_left=1.
- beat_accept pulsed with grant_valid=0 -> protocol_error=1 the next cycle, still 1 after 10 cycles, cleared only by rst.
- rst asserted in the middle of port 1's packet -> the next cycle shows grant_valid=0, grant_id=0, credits_left=0; with both ports requesting, the pointer restarts at 0 and port 0 is granted first.
